ads42_spi_master: RTL and testbench



---
 rtl/ads42_spi_master.sv | 204 ++++++++++++++++++++
 tb/tb_ads42_spi_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ads42_spi_master.sv
// ads42_spi_master
//   SPI serial engine between the ADS42 configuration controller and the
//   ADC serial pins. Each start request shifts one 16-bit command word out
//   MSB first on o_spi_sdata, framed by o_spi_sen (active low) and clocked
//   by o_spi_sclk (idle low). Each transfer ends with a one-cycle o_spi_done.
//
//   Optional readback path: define ADS42_SPI_RDBK_EN to enable it.
//   When it is enabled, i_spi_sdout is sampled on the last sys_clk cycle of
//   every SCLK high half. The final byte is presented on o_dat_out, together
//   with o_dat_vaild, in the o_spi_done cycle. When it is not enabled,
//   o_dat_out and o_dat_vaild are tied to 0.
//
// Ports
//   sys_clk      system clock
//   rst          synchronous, active-high reset
//   i_dat_in     command word {rw[1:0], addr[5:0], data[7:0]}
//   i_opt_start  transfer request level; a rising edge in IDLE launches
//   i_opt_cnt    number of bits to shift (0 or >16 means 16)
//   o_dat_out    last captured read byte
//   o_dat_vaild  one-cycle strobe marking an o_dat_out update
//   o_spi_done   one-cycle end-of-transfer pulse
//   o_spi_sen    ADC serial enable, active low
//   o_spi_sclk   serial clock, idle low
//   o_spi_sdata  serial data to the ADC
//   i_spi_sdout  serial readback data from the ADC
//
// Handshake: i_opt_start is a level request. A launch requires i_opt_start=1,
//   its registered copy=0 and the FSM in IDLE. Edges that arrive outside
//   IDLE are dropped. The controller holds i_opt_start high until
//   o_spi_done, and must drop it before it requests the next transfer.
module ads42_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [15:0] i_dat_in,
  input  logic        i_opt_start,
  input  logic [7:0]  i_opt_cnt,
  output logic [7:0]  o_dat_out,
  output logic        o_dat_vaild,
  output logic        o_spi_done,
  output logic        o_spi_sen,
  output logic        o_spi_sclk,
  output logic        o_spi_sdata,
  input  logic        i_spi_sdout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t      state;
  state_t      state_nx;
  logic        start_q;
  logic [7:0]  tmr;
  logic        sclk_hi;
  logic [4:0]  bits_left;
  logic [15:0] sh;
  logic [4:0]  n_launch;
  logic        launch;
  logic        setup_end;
  logic        half_end;
  logic        hold_end;
  logic        last_bit;
  logic        sample_now;

  // Out-of-range counts fall back to a full 16-bit word.
  assign n_launch   = ((i_opt_cnt == 8'd0) || (i_opt_cnt > 8'd16)) ? 5'd16 : i_opt_cnt[4:0];
  assign launch     = i_opt_start && !start_q && (state == IDLE);
  assign setup_end  = (tmr == SETUP_LAST);
  assign half_end   = (tmr == HALF_LAST);
  assign hold_end   = (tmr == HOLD_LAST);
  assign last_bit   = (bits_left == 5'd1);
  // Last sys_clk cycle of an SCLK high half.
  assign sample_now = (state == SHIFT) && sclk_hi && half_end;

  // FSM: state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = SETUP;
      SETUP:   if (setup_end) state_nx = SHIFT;
      SHIFT:   if (sample_now && last_bit) state_nx = HOLD;
      HOLD:    if (hold_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_spi_sen   = 1'b1;
    o_spi_sclk  = 1'b0;
    o_spi_sdata = 1'b0;
    o_spi_done  = 1'b0;
    case (state)
      SETUP, HOLD: begin
        o_spi_sen   = 1'b0;
        o_spi_sdata = sh[15];
      end
      SHIFT: begin
        o_spi_sen   = 1'b0;
        o_spi_sclk  = sclk_hi;
        o_spi_sdata = sh[15];
      end
      DONE:    o_spi_done = 1'b1;
      default: ;
    endcase
  end

  // Timing counter, SCLK phase, bit counter and transmit shift register.
  // The start-edge register resets high so that a start level held through
  // reset does not count as a rising edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      start_q   <= 1'b1;
      tmr       <= 8'd0;
      sclk_hi   <= 1'b0;
      bits_left <= 5'd0;
      sh        <= 16'd0;
    end else begin
      start_q <= i_opt_start;
      case (state)
        IDLE: begin
          tmr     <= 8'd0;
          sclk_hi <= 1'b0;
          if (launch) begin
            sh        <= i_dat_in;
            bits_left <= n_launch;
          end
        end
        SETUP: tmr <= setup_end ? 8'd0 : tmr + 8'd1;
        SHIFT: begin
          if (half_end) begin
            tmr     <= 8'd0;
            sclk_hi <= ~sclk_hi;
            if (sclk_hi) begin
              // The end of a high half is the SCLK fall, so SDATA moves to
              // the next bit here. It holds the last bit through HOLD.
              bits_left <= bits_left - 5'd1;
              if (!last_bit) sh <= {sh[14:0], 1'b0};
            end
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        HOLD:    tmr <= hold_end ? 8'd0 : tmr + 8'd1;
        default: tmr <= 8'd0;
      endcase
    end
  end

`ifdef ADS42_SPI_RDBK_EN
  logic [7:0] rd_sh;
  logic [7:0] dat_q;

  // Samples shift in at the LSB. The register clears at launch, so a short
  // transfer leaves its samples right-aligned over zeros. The byte moves to
  // the output on the HOLD->DONE edge, so o_dat_out is already valid during
  // the DONE cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd_sh <= 8'd0;
      dat_q <= 8'd0;
    end else begin
      if (launch) begin
        rd_sh <= 8'd0;
      end else if (sample_now) begin
        rd_sh <= {rd_sh[6:0], i_spi_sdout};
      end
      if ((state == HOLD) && hold_end) dat_q <= rd_sh;
    end
  end

  assign o_dat_out   = dat_q;
  assign o_dat_vaild = (state == DONE);
`else
  logic unused_sdout;

  assign unused_sdout = i_spi_sdout;
  assign o_dat_out    = 8'd0;
  assign o_dat_vaild  = 1'b0;
`endif

endmodule

// File: tb/tb_ads42_spi_master.sv
// Testbench for ads42_spi_master (default parameters). Expected transfer
// results are pushed to exp_q when a transfer is launched. They are popped
// and compared once the transfer has been observed. Cycle numbers count
// sys_clk periods after the launch cycle (cycle 0). Outputs are sampled on
// the falling edge.
module tb_ads42_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;

  logic        sys_clk;
  logic        rst;
  logic [15:0] i_dat_in;
  logic        i_opt_start;
  logic [7:0]  i_opt_cnt;
  logic [7:0]  o_dat_out;
  logic        o_dat_vaild;
  logic        o_spi_done;
  logic        o_spi_sen;
  logic        o_spi_sclk;
  logic        o_spi_sdata;
  logic        i_spi_sdout;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  ads42_spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .i_dat_in   (i_dat_in),
    .i_opt_start(i_opt_start),
    .i_opt_cnt  (i_opt_cnt),
    .o_dat_out  (o_dat_out),
    .o_dat_vaild(o_dat_vaild),
    .o_spi_done (o_spi_done),
    .o_spi_sen  (o_spi_sen),
    .o_spi_sclk (o_spi_sclk),
    .o_spi_sdata(o_spi_sdata),
    .i_spi_sdout(i_spi_sdout)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected results for one transfer, in the order in which xfer pops them.
  task automatic push_expect(input logic [15:0] word, input logic [7:0] cnt,
                             input logic [15:0] sd_pat);
    int n;
    n = ((cnt == 8'd0) || (cnt > 8'd16)) ? 16 : int'(cnt);
    exp_q.push_back(16'd1);                                   // SEN fall cycle
    exp_q.push_back(16'(n));                                  // SCLK rises
    exp_q.push_back(word >> (16 - n));                        // bits on rises
    exp_q.push_back(16'(2 * CLK_DIV));                        // SCLK period
    exp_q.push_back(16'(1 + CS_SETUP + 2 * CLK_DIV * n + CS_HOLD)); // done cycle
    exp_q.push_back(16'd1);                                   // done pulses
    exp_q.push_back(16'd1);                                   // SEN high at done
`ifdef ADS42_SPI_RDBK_EN
    exp_q.push_back({8'h00, 8'(sd_pat >> (16 - n))});
    exp_q.push_back(16'd1);                                   // valid pulses
    exp_q.push_back(16'd1);                                   // valid with done
`else
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
`endif
  endtask

  // Driver plus monitor for one transfer. The ADC model drives sd_pat[15-b]
  // on i_spi_sdout during bit b. hold_until=0 drops start on done, otherwise
  // start drops at that cycle. glitch_at!=0 pulses start low for one cycle.
  task automatic xfer(input string tag, input logic [15:0] word, input logic [7:0] cnt,
                      input logic [15:0] sd_pat, input int hold_until,
                      input int glitch_at, input int win);
    int sen_fall = 0, rises = 0, r0 = 0, r1 = 0, done_c = 0, done_n = 0;
    int valid_n = 0, valid_done = 0;
    logic [15:0] cap = 16'd0;
    logic sen_at_done = 1'b0;
    logic [7:0] dat_at_done = 8'd0;
    logic prev_sen = 1'b1, prev_sclk = 1'b0;
    @(negedge sys_clk);
    i_dat_in    = word;
    i_opt_cnt   = cnt;
    i_opt_start = 1'b1;
    push_expect(word, cnt, sd_pat);
    for (int c = 1; c <= win; c++) begin
      @(negedge sys_clk);
      if (c == 2) begin
        i_dat_in  = ~word;
        i_opt_cnt = 8'd5;
      end
      if (prev_sen && !o_spi_sen && sen_fall == 0) sen_fall = c;
      if (o_spi_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[14:0], o_spi_sdata};
        if (rises == 1) r0 = c;
        if (rises == 2) r1 = c;
        if (rises <= 16) i_spi_sdout = sd_pat[16 - rises];
      end
      if (o_spi_done) begin
        done_n++;
        if (done_c == 0) begin
          done_c      = c;
          sen_at_done = o_spi_sen;
          dat_at_done = o_dat_out;
        end
      end
      if (o_dat_vaild) begin
        valid_n++;
        if (o_spi_done) valid_done++;
      end
      prev_sen  = o_spi_sen;
      prev_sclk = o_spi_sclk;
      if (glitch_at != 0 && c == glitch_at) i_opt_start = 1'b0;
      if (glitch_at != 0 && c == glitch_at + 1) i_opt_start = 1'b1;
      if ((hold_until == 0 && o_spi_done) || (hold_until != 0 && c == hold_until))
        i_opt_start = 1'b0;
    end
    i_opt_start = 1'b0;
    check({tag, " sen_fall"},    16'(sen_fall),    exp_q.pop_front());
    check({tag, " sclk_rises"},  16'(rises),       exp_q.pop_front());
    check({tag, " sdata_bits"},  cap,              exp_q.pop_front());
    check({tag, " sclk_period"}, 16'(r1 - r0),     exp_q.pop_front());
    check({tag, " done_cycle"},  16'(done_c),      exp_q.pop_front());
    check({tag, " done_pulses"}, 16'(done_n),      exp_q.pop_front());
    check({tag, " sen_at_done"}, 16'(sen_at_done), exp_q.pop_front());
    check({tag, " dat_out"},     {8'h00, dat_at_done}, exp_q.pop_front());
    check({tag, " valid_pulses"}, 16'(valid_n),    exp_q.pop_front());
    check({tag, " valid_at_done"}, 16'(valid_done), exp_q.pop_front());
  endtask

  initial begin
    int sen_low;
    int done_seen;
    rst         = 1'b1;
    i_dat_in    = 16'd0;
    i_opt_cnt   = 8'd16;
    i_opt_start = 1'b1;
    i_spi_sdout = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset sen",   16'(o_spi_sen),   16'd1);
    check("reset sclk",  16'(o_spi_sclk),  16'd0);
    check("reset sdata", 16'(o_spi_sdata), 16'd0);
    check("reset done",  16'(o_spi_done),  16'd0);
    check("reset valid", 16'(o_dat_vaild), 16'd0);
    check("reset dat",   {8'h00, o_dat_out}, 16'd0);

    // Start held high through reset: must not launch.
    rst = 1'b0;
    sen_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (!o_spi_sen) sen_low++;
    end
    check("start_through_reset sen_low", 16'(sen_low), 16'd0);
    i_opt_start = 1'b0;
    @(negedge sys_clk);

    xfer("write_8680", 16'h8680, 8'd16, 16'($urandom_range(0, 65535)), 0, 0, 150);
    xfer("read_C0A5",  16'hC0A5, 8'd16, 16'h003C, 0, 0, 150);
    xfer("cnt8_1234",  16'h1234, 8'd8,  16'($urandom_range(0, 65535)), 0, 0, 100);
    xfer("cnt3_E000",  16'hE000, 8'd3,  16'h5000, 0, 0, 60);
    xfer("cnt0_A5C3",  16'hA5C3, 8'd0,  16'($urandom_range(0, 65535)), 0, 0, 150);
    xfer("cnt20_5A3C", 16'h5A3C, 8'h20, 16'($urandom_range(0, 65535)), 0, 0, 150);
    xfer("held_300",   16'h0F0F, 8'd16, 16'($urandom_range(0, 65535)), 300, 0, 310);
    xfer("glitch",     16'hF00F, 8'd16, 16'($urandom_range(0, 65535)), 0, 20, 150);
    repeat (256) @(negedge sys_clk);
    xfer("after_gap",  16'h6C93, 8'd16, 16'($urandom_range(0, 65535)), 0, 0, 150);

    // Reset during bit 5 with start still high.
    @(negedge sys_clk);
    i_dat_in    = 16'hFFFF;
    i_opt_cnt   = 8'd16;
    i_opt_start = 1'b1;
    repeat (1 + CS_SETUP + 2 * CLK_DIV * 4 + 1) @(negedge sys_clk);
    check("pre_abort sclk_phase_sen", 16'(o_spi_sen), 16'd0);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("abort sen",   16'(o_spi_sen),   16'd1);
    check("abort sclk",  16'(o_spi_sclk),  16'd0);
    check("abort done",  16'(o_spi_done),  16'd0);
    check("abort valid", 16'(o_dat_vaild), 16'd0);
    sen_low   = 0;
    done_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge sys_clk);
      if (!o_spi_sen) sen_low++;
      if (o_spi_done || o_dat_vaild) done_seen++;
    end
    check("post_abort sen_low", 16'(sen_low),   16'd0);
    check("post_abort done",    16'(done_seen), 16'd0);
    i_opt_start = 1'b0;
    @(negedge sys_clk);
    xfer("after_abort", 16'hC0A5, 8'd16, 16'h00A7, 0, 0, 150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
